bnn_layer_sequencer: RTL



---
 rtl/bnn_pkg.sv | 28 ++
 rtl/bnn_xnor_popcount.sv | 22 ++
 rtl/bnn_layer_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared types and default sizes for the microgreen BNN layer sequencer.
package bnn_pkg;

  localparam int IN_BITS = 16;
  localparam int HID     = 8;
  localparam int CLASSES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HID,
    ST_OUT,
    ST_DONE
  } state_t;

  // Ceiling log2, evaluated at elaboration time to size counters and indices.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: number of bit positions where a and b agree.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  output logic [clog2(W+1)-1:0]   count
);

  localparam int CW = clog2(W + 1);

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps synthesis from inferring a latch.
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(~(a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Sequences hidden then output XNOR-popcount layers against an external weight memory.
// Optional BNN_SCORE_OUT_EN exposes the winning popcount on score_out.
module bnn_layer_sequencer #(
  parameter int IN_BITS = bnn_pkg::IN_BITS,
  parameter int HID     = bnn_pkg::HID,
  parameter int CLASSES = bnn_pkg::CLASSES,
  parameter int HID_THR = 8,
  parameter int AW      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ena,
  input  logic                                feat_valid,
  input  logic [IN_BITS-1:0]                  feat_in,
  output logic                                feat_ready,
  output logic                                w_req,
  output logic [AW-1:0]                       w_addr,
  input  logic [IN_BITS-1:0]                  w_data,
  input  logic                                w_ack,
  output logic                                busy,
  output logic [HID-1:0]                      hidden_out,
  output logic [bnn_pkg::clog2(CLASSES)-1:0]  class_out,
  output logic                                class_valid
`ifdef BNN_SCORE_OUT_EN
  ,
  output logic [bnn_pkg::clog2(HID+1)-1:0]    score_out
`endif
);

  import bnn_pkg::*;

  localparam int CW  = clog2(IN_BITS + 1);
  localparam int BW  = clog2(HID + 1);
  localparam int CLW = clog2(CLASSES);
  localparam int PAD = IN_BITS - HID;

  state_t              state, state_nxt;
  logic [IN_BITS-1:0]  feat;
  logic [BW-1:0]       best;
  logic [IN_BITS-1:0]  pc_a, pc_b;
  logic [CW-1:0]       pop;
  logic [BW-1:0]       pop_out;
  logic [AW-1:0]       k;
  logic                hid_last, out_last, take_out;

  // Output layer reuses the same popcounter; the zero padding always agrees, so remove it afterwards.
  always_comb begin
    pc_a = feat;
    pc_b = w_data;
    if (state == ST_OUT) begin
      pc_a = IN_BITS'(hidden_out);
      pc_b = IN_BITS'(w_data[HID-1:0]);
    end
  end

  bnn_xnor_popcount #(.W(IN_BITS)) u_popcount (
    .a     (pc_a),
    .b     (pc_b),
    .count (pop)
  );

  assign pop_out  = BW'(pop - CW'(PAD));
  assign k        = w_addr - AW'(HID);
  assign hid_last = (w_addr == AW'(HID - 1));
  assign out_last = (k == AW'(CLASSES - 1));
  assign take_out = (k == '0) || (pop_out > best);

  always_comb begin
    state_nxt   = state;
    w_req       = 1'b0;
    feat_ready  = 1'b0;
    class_valid = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        feat_ready = ena;
        if (feat_valid) state_nxt = ST_HID;
      end
      ST_HID: begin
        w_req = 1'b1;
        if (w_ack && hid_last) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_req = 1'b1;
        if (w_ack && out_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Gated so a freeze while in DONE cannot stretch the pulse.
        class_valid = ena;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat       <= '0;
      w_addr     <= '0;
      hidden_out <= '0;
      class_out  <= '0;
      best       <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (feat_valid) begin
            feat   <= feat_in;
            w_addr <= '0;
          end
        end
        ST_HID: begin
          if (w_ack) begin
            for (int i = 0; i < HID; i++) begin
              if (w_addr == AW'(i)) hidden_out[i] <= (pop >= CW'(HID_THR));
            end
            w_addr <= w_addr + AW'(1);
          end
        end
        ST_OUT: begin
          if (w_ack) begin
            if (take_out) begin
              best      <= pop_out;
              class_out <= k[CLW-1:0];
            end
            if (!out_last) w_addr <= w_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BNN_SCORE_OUT_EN
  assign score_out = best;
`endif

endmodule
